pc_fetch_sequencer: RTL and testbench

Program-counter and instruction-fetch stage directly upstream of the `Jump` unit. It owns the 11-bit PC, fetches 18-bit instruction words over a request/acknowledge handshake, and splits each word into `opcode`, the 3-bit jump condition `IR` and the 11-bit `Address` field. It also holds the ZF/CF flag register that drives `Jump`. When the control unit signals completion, it loads the next PC from either `jumpAddress` or PC+1.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/pc_fetch_sequencer_if.sv | 17 +
 rtl/flag_register.sv | 29 ++
 rtl/pc_fetch_sequencer.sv | 119 +++++++++++
 tb/tb_pc_fetch_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types, field widths and instruction layout
// Holds the sequencer state encoding, instruction field widths and bit
// positions, and the default halt opcode.
package cpu_pkg;

    localparam int ADDR_W  = 11;
    localparam int COND_W  = 3;
    localparam int OP_W    = 4;
    localparam int INSTR_W = 18;

    // Instruction word layout: {opcode, cond, address}
    localparam int ADDR_LSB = 0;
    localparam int COND_LSB = ADDR_LSB + ADDR_W;
    localparam int OP_LSB   = COND_LSB + COND_W;

    localparam logic [OP_W-1:0] HALT_OP_DEFAULT = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// rtl/pc_fetch_sequencer_if.sv - instruction memory request/acknowledge bus
// Ports (signals):
//   imemReq  : fetch request (sequencer -> memory)
//   imemAddr : fetch address (sequencer -> memory)
//   imemAck  : data valid this cycle (memory -> sequencer)
//   imemData : 18-bit instruction word (memory -> sequencer)
interface pc_fetch_sequencer_if;
    import cpu_pkg::*;

    logic               imemReq;
    logic [ADDR_W-1:0]  imemAddr;
    logic               imemAck;
    logic [INSTR_W-1:0] imemData;

    modport master (output imemReq, imemAddr, input imemAck, imemData);
    modport slave  (input imemReq, imemAddr, output imemAck, imemData);
endinterface

// File: rtl/flag_register.sv
// rtl/flag_register.sv - ZF/CF flag register fed by the ALU
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flagWe       : load both flags this cycle
//   aluZ, aluC   : ALU zero / carry results
//   zf, cf       : registered flags
module flag_register (
    input  logic clk,
    input  logic rst_n,
    input  logic flagWe,
    input  logic aluZ,
    input  logic aluC,
    output logic zf,
    output logic cf
);

    // A load in the same cycle as execDone only becomes visible next cycle,
    // so Jump always evaluates the flags as they were before this instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf <= 1'b0;
            cf <= 1'b0;
        end else if (flagWe) begin
            zf <= aluZ;
            cf <= aluC;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - PC, instruction fetch, field decode and flags
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   imem             : instruction memory bus (master side)
//   PC               : current program counter
//   IR, Address      : captured condition and address fields
//   opcode           : captured opcode
//   decodeValid      : fields hold a live instruction (EXEC)
//   execDone         : control unit finished the current instruction
//   jumpSignal       : branch taken, sampled with execDone
//   jumpAddress      : branch target
//   flagWe, aluZ/C   : flag load enable and ALU results
//   ZF, CF           : registered flags
//   halted           : sequencer stopped on HALT_OP
module pc_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 11'd0,
    parameter logic [OP_W-1:0]   HALT_OP  = HALT_OP_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_fetch_sequencer_if.master imem,
    output logic [ADDR_W-1:0]    PC,
    output logic [COND_W-1:0]    IR,
    output logic [ADDR_W-1:0]    Address,
    output logic [OP_W-1:0]      opcode,
    output logic                 decodeValid,
    input  logic                 execDone,
    input  logic                 jumpSignal,
    input  logic [ADDR_W-1:0]    jumpAddress,
    input  logic                 flagWe,
    input  logic                 aluZ,
    input  logic                 aluC,
    output logic                 ZF,
    output logic                 CF,
    output logic                 halted
);

    state_t state;
    state_t nextState;

    logic [OP_W-1:0] fetchedOp;
    logic            fetchAccept;
    logic            execRetire;

    assign fetchedOp   = imem.imemData[OP_LSB +: OP_W];
    assign fetchAccept = (state == FETCH) && imem.imemAck;
    assign execRetire  = (state == EXEC) && execDone;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // imemReq is additionally qualified by rst_n so that it reads 0 while
    // reset is held, even though the reset state is FETCH.
    always_comb begin
        nextState     = state;
        imem.imemReq  = 1'b0;
        decodeValid   = 1'b0;
        halted        = 1'b0;
        case (state)
            FETCH: begin
                imem.imemReq = rst_n;
                if (imem.imemAck) begin
                    nextState = (fetchedOp == HALT_OP) ? HALT : EXEC;
                end
            end
            EXEC: begin
                decodeValid = 1'b1;
                if (execDone) begin
                    nextState = FETCH;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                nextState = FETCH;
            end
        endcase
    end

    assign imem.imemAddr = PC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC      <= RESET_PC;
            IR      <= '0;
            Address <= '0;
            opcode  <= '0;
        end else begin
            if (fetchAccept) begin
                IR      <= imem.imemData[COND_LSB +: COND_W];
                Address <= imem.imemData[ADDR_LSB +: ADDR_W];
                opcode  <= fetchedOp;
            end
            if (execRetire) begin
                // PC+1 wraps naturally at the 11-bit width.
                PC <= jumpSignal ? jumpAddress : PC + 11'd1;
            end
        end
    end

    flag_register u_flags (
        .clk    (clk),
        .rst_n  (rst_n),
        .flagWe (flagWe),
        .aluZ   (aluZ),
        .aluC   (aluC),
        .zf     (ZF),
        .cf     (CF)
    );

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - directed and randomized bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] pc;
    logic [2:0]  ir;
    logic [10:0] address;
    logic [3:0]  opcode;
    logic        decodeValid;
    logic        execDone = 1'b0;
    logic        jumpSignal = 1'b0;
    logic [10:0] jumpAddress = '0;
    logic        flagWe = 1'b0;
    logic        aluZ = 1'b0;
    logic        aluC = 1'b0;
    logic        zf;
    logic        cf;
    logic        halted;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mPc  = 0;
    bit mZf  = 0;
    bit mCf  = 0;
    bit randomFlags = 0;

    pc_fetch_sequencer_if bus ();

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus.master),
        .PC          (pc),
        .IR          (ir),
        .Address     (address),
        .opcode      (opcode),
        .decodeValid (decodeValid),
        .execDone    (execDone),
        .jumpSignal  (jumpSignal),
        .jumpAddress (jumpAddress),
        .flagWe      (flagWe),
        .aluZ        (aluZ),
        .aluC        (aluC),
        .ZF          (zf),
        .CF          (cf),
        .halted      (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkFlags(input string tag);
        chk({tag, ".ZF"}, 32'(zf), 32'(mZf));
        chk({tag, ".CF"}, 32'(cf), 32'(mCf));
    endtask

    // Drive the flag inputs for the coming edge; the model applies them after it.
    task automatic driveIdleFlags(output bit we, output bit z, output bit c);
        we = randomFlags ? 1'($urandom_range(0, 1)) : 1'b0;
        z  = 1'($urandom_range(0, 1));
        c  = 1'($urandom_range(0, 1));
        flagWe = we;
        aluZ   = z;
        aluC   = c;
    endtask

    // Entry/exit: just after a falling edge, sequencer in FETCH.
    task automatic fetch(input logic [17:0] word, input int ackDelay);
        bit we, z, c;
        for (int i = 0; i < ackDelay; i++) begin
            bus.imemAck  = 1'b0;
            bus.imemData = 18'($urandom);
            execDone     = 1'($urandom_range(0, 1));
            jumpSignal   = 1'($urandom_range(0, 1));
            jumpAddress  = 11'($urandom);
            driveIdleFlags(we, z, c);
            @(negedge clk);
            if (we) begin mZf = z; mCf = c; end
            chk("wait.imemReq", 32'(bus.imemReq), 32'd1);
            chk("wait.imemAddr", 32'(bus.imemAddr), 32'(mPc));
            chk("wait.decodeValid", 32'(decodeValid), 32'd0);
        end
        bus.imemAck  = 1'b1;
        bus.imemData = word;
        execDone     = 1'b0;
        driveIdleFlags(we, z, c);
        @(negedge clk);
        if (we) begin mZf = z; mCf = c; end
        bus.imemAck  = 1'b0;
        bus.imemData = 18'($urandom);
        chk("cap.opcode", 32'(opcode), 32'(word[17:14]));
        chk("cap.IR", 32'(ir), 32'(word[13:11]));
        chk("cap.Address", 32'(address), 32'(word[10:0]));
        chk("cap.imemReq", 32'(bus.imemReq), 32'd0);
        if (word[17:14] == 4'hF) begin
            chk("cap.halted", 32'(halted), 32'd1);
            chk("cap.decodeValid", 32'(decodeValid), 32'd0);
        end else begin
            chk("cap.decodeValid", 32'(decodeValid), 32'd1);
            chk("cap.halted", 32'(halted), 32'd0);
        end
        checkFlags("cap");
    endtask

    // Entry: just after a falling edge in the first EXEC cycle.
    // Exit: just after the falling edge of the following FETCH cycle.
    task automatic exec(input logic [17:0] word, input int waitN, input bit jump,
                        input logic [10:0] jaddr, input bit doneWe,
                        input bit doneZ, input bit doneC);
        bit we, z, c;
        for (int i = 0; i < waitN; i++) begin
            execDone     = 1'b0;
            jumpSignal   = 1'($urandom_range(0, 1));
            jumpAddress  = 11'($urandom);
            bus.imemAck  = 1'($urandom_range(0, 1));
            bus.imemData = 18'($urandom);
            driveIdleFlags(we, z, c);
            @(negedge clk);
            if (we) begin mZf = z; mCf = c; end
            chk("exec.decodeValid", 32'(decodeValid), 32'd1);
            chk("exec.IR", 32'(ir), 32'(word[13:11]));
            chk("exec.Address", 32'(address), 32'(word[10:0]));
            chk("exec.opcode", 32'(opcode), 32'(word[17:14]));
            chk("exec.PC", 32'(pc), 32'(mPc));
            checkFlags("exec");
        end
        bus.imemAck  = 1'b0;
        execDone     = 1'b1;
        jumpSignal   = jump;
        jumpAddress  = jaddr;
        flagWe       = doneWe;
        aluZ         = doneZ;
        aluC         = doneC;
        #1;
        checkFlags("done.preupdate");
        @(negedge clk);
        execDone = 1'b0;
        flagWe   = 1'b0;
        mPc = jump ? int'(jaddr) : (mPc + 1) % 2048;
        if (doneWe) begin mZf = doneZ; mCf = doneC; end
        chk("next.PC", 32'(pc), 32'(mPc));
        chk("next.imemAddr", 32'(bus.imemAddr), 32'(mPc));
        chk("next.imemReq", 32'(bus.imemReq), 32'd1);
        chk("next.decodeValid", 32'(decodeValid), 32'd0);
        checkFlags("next");
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        #1;
        mPc = 0; mZf = 0; mCf = 0;
        chk("rst.imemReq", 32'(bus.imemReq), 32'd0);
        chk("rst.decodeValid", 32'(decodeValid), 32'd0);
        chk("rst.halted", 32'(halted), 32'd0);
        chk("rst.PC", 32'(pc), 32'd0);
        chk("rst.IR", 32'(ir), 32'd0);
        chk("rst.Address", 32'(address), 32'd0);
        chk("rst.opcode", 32'(opcode), 32'd0);
        checkFlags("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.imemReq", 32'(bus.imemReq), 32'd1);
        chk("rel.imemAddr", 32'(bus.imemAddr), 32'd0);
    endtask

    initial begin
        logic [17:0] w;
        bus.imemAck  = 1'b0;
        bus.imemData = '0;

        // Reset values and delayed first ack.
        #2;
        applyReset();
        w = {4'h1, 3'b001, 11'd6};
        fetch(w, 3);
        exec(w, 1, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0);

        // Taken branch to 1025.
        fetch(w, 0);
        exec(w, 0, 1'b1, 11'd1025, 1'b0, 1'b0, 1'b0);

        // Jump to 2047 then wrap to 0 on a not-taken instruction.
        w = {4'h2, 3'b101, 11'd77};
        fetch(w, 1);
        exec(w, 2, 1'b1, 11'd2047, 1'b0, 1'b0, 1'b0);
        fetch(w, 0);
        exec(w, 0, 1'b0, 11'd5, 1'b0, 1'b0, 1'b0);

        // Flag load coincident with execDone, then HALT.
        w = {4'h3, 3'b010, 11'd300};
        fetch(w, 0);
        exec(w, 0, 1'b0, 11'd0, 1'b1, 1'b1, 1'b0);
        w = {4'hF, 3'b111, 11'd9};
        fetch(w, 2);
        randomFlags = 1;
        for (int i = 0; i < 4; i++) begin
            bit we, z, c;
            bus.imemAck  = 1'b1;
            bus.imemData = 18'($urandom);
            execDone     = 1'($urandom_range(0, 1));
            driveIdleFlags(we, z, c);
            @(negedge clk);
            if (we) begin mZf = z; mCf = c; end
            chk("halt.halted", 32'(halted), 32'd1);
            chk("halt.imemReq", 32'(bus.imemReq), 32'd0);
            chk("halt.PC", 32'(pc), 32'(mPc));
            chk("halt.opcode", 32'(opcode), 32'hF);
            checkFlags("halt");
        end
        bus.imemAck = 1'b0;
        execDone    = 1'b0;
        flagWe      = 1'b0;

        // Reset out of HALT, then reset in the middle of EXEC.
        applyReset();
        w = {4'h4, 3'b011, 11'd1000};
        fetch(w, 0);
        exec(w, 0, 1'b1, 11'd512, 1'b1, 1'b1, 1'b1);
        fetch(w, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midexec.decodeValid", 32'(decodeValid), 32'd0);
        applyReset();

        // Randomized instruction stream against the model.
        for (int n = 0; n < 40; n++) begin
            w = {4'($urandom_range(0, 14)), 3'($urandom), 11'($urandom)};
            fetch(w, $urandom_range(0, 3));
            exec(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 11'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        w = {4'hF, 3'($urandom), 11'($urandom)};
        fetch(w, $urandom_range(0, 3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
